// File: rtl/spi_xfer_sched.sv
// Shares one 32-bit SPI master between a DAC write stream and a periodic ADC
// read trigger; issues two configuration writes after reset, then round-robin.
module spi_xfer_sched #(
    parameter logic [31:0] INIT_CMD0  = 32'h0000_0000,
    parameter logic [31:0] INIT_CMD1  = 32'h0000_0000,
    parameter int unsigned SAMPLE_DIV = 1000,
    parameter int unsigned GAP        = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        dac_valid_i,
    input  logic [31:0] dac_data_i,
    output logic        dac_ready_o,
    input  logic        sample_en_i,
    output logic        adc_valid_o,
    output logic [15:0] adc_data_o,
    output logic        overrun_o,
    output logic        init_done_o,
    output logic        busy_o,
    output logic        spi_writ_flag_o,
    output logic        spi_read_flag_o,
    output logic [31:0] spi_writ_data_o,
    input  logic [32:0] spi_read_data_i
);
    localparam int unsigned TW            = $clog2(SAMPLE_DIV);
    localparam int unsigned GW            = (GAP > 1) ? $clog2(GAP) : 1;
    localparam int unsigned GAP_LAST      = GAP - 1;
    localparam int unsigned GAP_INIT_LAST = (GAP > 1) ? GAP - 2 : 0;

    typedef enum logic [2:0] {
        S_INIT0, S_INIT1, S_IDLE, S_ISSUE, S_WAIT, S_GAPW
    } state_e;

    state_e          state_q, state_d;
    logic [4:0]      wcnt_q, wcnt_d;
    logic [GW-1:0]   gcnt_q, gcnt_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic            read_pend_q, read_pend_d;
    logic            last_read_q, last_read_d;
    logic            is_read_q, is_read_d;
    logic            cmd1_q, cmd1_d;
    logic            init_done_q, init_done_d;
    logic [31:0]     shadow_q, shadow_d;
    logic [31:0]     writ_data_q, writ_data_d;
    logic [15:0]     adc_data_q, adc_data_d;
    logic            adc_valid_q, adc_valid_d;
    logic            writ_flag_q, writ_flag_d;
    logic            read_flag_q, read_flag_d;
    logic            overrun_q, overrun_d;
    logic            busy_q, busy_d;
    logic            grant_read;
    logic            timer_run;
    logic            tick;

    // Next-state, grant and sample-timer logic
    always_comb begin
        state_d     = state_q;
        wcnt_d      = wcnt_q;
        gcnt_d      = gcnt_q;
        last_read_d = last_read_q;
        is_read_d   = is_read_q;
        cmd1_d      = cmd1_q;
        init_done_d = init_done_q;
        shadow_d    = shadow_q;
        writ_data_d = writ_data_q;
        adc_data_d  = adc_data_q;
        adc_valid_d = 1'b0;
        writ_flag_d = 1'b0;
        read_flag_d = 1'b0;
        dac_ready_o = 1'b0;
        grant_read  = 1'b0;

        unique case (state_q)
            S_INIT0: begin
                writ_data_d = INIT_CMD0;
                is_read_d   = 1'b0;
                cmd1_d      = 1'b0;
                writ_flag_d = 1'b1;
                state_d     = S_ISSUE;
            end
            S_INIT1: begin
                writ_data_d = INIT_CMD1;
                is_read_d   = 1'b0;
                cmd1_d      = 1'b1;
                writ_flag_d = 1'b1;
                state_d     = S_ISSUE;
            end
            S_IDLE: begin
                // On contention the DAC wins only if the read went last
                if (dac_valid_i && (!read_pend_q || last_read_q)) begin
                    dac_ready_o = 1'b1;
                    writ_data_d = dac_data_i;
                    is_read_d   = 1'b0;
                    last_read_d = 1'b0;
                    writ_flag_d = 1'b1;
                    state_d     = S_ISSUE;
                end else if (read_pend_q) begin
                    grant_read  = 1'b1;
                    is_read_d   = 1'b1;
                    last_read_d = 1'b1;
                    read_flag_d = 1'b1;
                    state_d     = S_ISSUE;
                end
            end
            S_ISSUE: begin
                wcnt_d  = 5'd0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (is_read_q) begin
                    shadow_d[5'd31 - wcnt_q] = spi_read_data_i[6'd32 - {1'b0, wcnt_q}];
                end
                wcnt_d = wcnt_q + 5'd1;
                if (wcnt_q == 5'd31) begin
                    gcnt_d = '0;
                    if (is_read_q) begin
                        adc_data_d  = shadow_q[31:16];
                        adc_valid_d = 1'b1;
                    end
                    if (!init_done_q && !cmd1_q && GAP == 1) begin
                        state_d = S_INIT1;
                    end else begin
                        state_d = S_GAPW;
                    end
                end
            end
            S_GAPW: begin
                gcnt_d = gcnt_q + GW'(1);
                // INIT1 itself stands in for the last gap cycle of the first config write
                if (!init_done_q && !cmd1_q && gcnt_q == GW'(GAP_INIT_LAST)) begin
                    state_d = S_INIT1;
                end else if (gcnt_q == GW'(GAP_LAST)) begin
                    state_d     = S_IDLE;
                    init_done_d = 1'b1;
                end
            end
            default: state_d = S_INIT0;
        endcase

        busy_d      = (state_d != S_IDLE);
        timer_run   = sample_en_i && init_done_q;
        tick        = timer_run && (timer_q == TW'(SAMPLE_DIV - 1));
        timer_d     = (!timer_run || tick) ? '0 : timer_q + TW'(1);
        read_pend_d = (read_pend_q && !grant_read) || tick;
        overrun_d   = tick && read_pend_q && !grant_read;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_INIT0;
            wcnt_q      <= '0;
            gcnt_q      <= '0;
            timer_q     <= '0;
            read_pend_q <= 1'b0;
            last_read_q <= 1'b1;
            is_read_q   <= 1'b0;
            cmd1_q      <= 1'b0;
            init_done_q <= 1'b0;
            shadow_q    <= '0;
            writ_data_q <= '0;
            adc_data_q  <= '0;
            adc_valid_q <= 1'b0;
            writ_flag_q <= 1'b0;
            read_flag_q <= 1'b0;
            overrun_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            gcnt_q      <= gcnt_d;
            timer_q     <= timer_d;
            read_pend_q <= read_pend_d;
            last_read_q <= last_read_d;
            is_read_q   <= is_read_d;
            cmd1_q      <= cmd1_d;
            init_done_q <= init_done_d;
            shadow_q    <= shadow_d;
            writ_data_q <= writ_data_d;
            adc_data_q  <= adc_data_d;
            adc_valid_q <= adc_valid_d;
            writ_flag_q <= writ_flag_d;
            read_flag_q <= read_flag_d;
            overrun_q   <= overrun_d;
            busy_q      <= busy_d;
        end
    end

    assign adc_valid_o     = adc_valid_q;
    assign adc_data_o      = adc_data_q;
    assign overrun_o       = overrun_q;
    assign init_done_o     = init_done_q;
    assign busy_o          = busy_q;
    assign spi_writ_flag_o = writ_flag_q;
    assign spi_read_flag_o = read_flag_q;
    assign spi_writ_data_o = writ_data_q;
endmodule

// File: tb/tb_spi_xfer_sched.sv
// Self-checking bench for spi_xfer_sched: DAC vector table, scoreboarded SPI
// words and ADC samples, a per-bit MISO model and reset/starvation sequences.
module tb_spi_xfer_sched;
    localparam int unsigned DIV = 40;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        dac_valid;
    logic [31:0] dac_data;
    logic        dac_ready;
    logic        sample_en;
    logic        adc_valid;
    logic [15:0] adc_data;
    logic        overrun;
    logic        init_done;
    logic        busy;
    logic        spi_writ_flag;
    logic        spi_read_flag;
    logic [31:0] spi_writ_data;
    logic [32:0] spi_read_data;

    spi_xfer_sched #(
        .INIT_CMD0(32'hA500_0001), .INIT_CMD1(32'h5A00_0002),
        .SAMPLE_DIV(DIV), .GAP(2)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .dac_valid_i(dac_valid), .dac_data_i(dac_data), .dac_ready_o(dac_ready),
        .sample_en_i(sample_en), .adc_valid_o(adc_valid), .adc_data_o(adc_data),
        .overrun_o(overrun), .init_done_o(init_done), .busy_o(busy),
        .spi_writ_flag_o(spi_writ_flag), .spi_read_flag_o(spi_read_flag),
        .spi_writ_data_o(spi_writ_data), .spi_read_data_i(spi_read_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        int          exp_lat;
        int          exp_busy;
    } dac_vec_t;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [31:0] exp_wr[$];
    logic [15:0] exp_adc[$];
    int wr_cyc_q[$];
    int rd_cyc_q[$];
    bit grants[$];
    int last_wr_cyc = -1000, last_rd_cyc = -1000;
    int reads = 0, adcs = 0, ovr = 0, ovr_double = 0, dr_init = 0, ticks = 0, en_run = 0;
    bit prev_ovr = 1'b0;
    bit auto_dac = 1'b0;
    bit first_rd = 1'b1;
    int rd_k = -1;
    logic [31:0] rd_word;
    logic [32:0] rd_rand;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    // Cycle counter and independent model of the sample timer ticks
    always @(posedge clk) begin
        cyc++;
        if (sample_en) begin
            en_run++;
            if (en_run == DIV) begin
                ticks++;
                en_run = 0;
            end
        end else begin
            en_run = 0;
        end
    end

    // Output monitor / scoreboard
    always @(negedge clk) begin
        if (spi_writ_flag) begin
            wr_cyc_q.push_back(cyc);
            last_wr_cyc = cyc;
            grants.push_back(1'b0);
            chk("wr_expected", exp_wr.size() > 0, 1);
            if (exp_wr.size() > 0) chk("wr_data", spi_writ_data, exp_wr.pop_front());
        end
        if (spi_read_flag) begin
            rd_cyc_q.push_back(cyc);
            last_rd_cyc = cyc;
            reads++;
            grants.push_back(1'b1);
        end
        if (adc_valid) begin
            adcs++;
            chk("adc_latency", cyc - last_rd_cyc, 33);
            chk("adc_expected", exp_adc.size() > 0, 1);
            if (exp_adc.size() > 0) chk("adc_data", adc_data, exp_adc.pop_front());
        end
        if (overrun) ovr++;
        if (overrun && prev_ovr) ovr_double++;
        prev_ovr = overrun;
        if (dac_ready && !init_done) dr_init++;
    end

    // SPI master MISO model: drives bit 32-k on transfer cycle k, others random
    always @(negedge clk) begin
        if (!rst_n) begin
            rd_k = -1;
        end else if (spi_read_flag) begin
            rd_word = first_rd ? 32'hBEEF_0000 : $urandom;
            first_rd = 1'b0;
            exp_adc.push_back(rd_word[31:16]);
            rd_k = 0;
        end else if (rd_k >= 0 && rd_k < 32) begin
            rd_rand = {1'($urandom), $urandom};
            rd_rand[32 - rd_k] = rd_word[31 - rd_k];
            spi_read_data = rd_rand;
            rd_k++;
        end
    end

    // Continuous DAC source for the contention phase
    always @(negedge clk) begin
        if (auto_dac && dac_valid && dac_ready) begin
            exp_wr.push_back(dac_data);
            @(posedge clk);
            #1 dac_data = $urandom;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        dac_vec_t vecs[4];
        int rel, n, e, gi0, gi1, first_r, viol, r0, adcs0, wi;
        vecs[0] = '{32'h1234_5678, 1, 35};
        vecs[1] = '{32'h0000_0000, 1, 35};
        vecs[2] = '{32'hFFFF_FFFF, 1, 35};
        vecs[3] = '{32'h8000_0001, 1, 35};

        rst_n = 1'b0; dac_valid = 1'b0; dac_data = '0; sample_en = 1'b0;
        spi_read_data = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_dac_ready", dac_ready, 0);
        chk("rst_adc_valid", adc_valid, 0);
        chk("rst_adc_data", adc_data, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_init_done", init_done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_writ_flag", spi_writ_flag, 0);
        chk("rst_read_flag", spi_read_flag, 0);
        chk("rst_writ_data", spi_writ_data, 0);

        // Configuration writes after reset release
        exp_wr.push_back(32'hA500_0001);
        exp_wr.push_back(32'h5A00_0002);
        @(negedge clk);
        rst_n = 1'b1;
        rel = cyc;
        n = 0;
        while (!init_done && n < 200) begin @(negedge clk); #1; n++; end
        chk("init_done_timeout", init_done, 1);
        chk("init_wr_count", wr_cyc_q.size(), 2);
        if (wr_cyc_q.size() == 2) begin
            chk("init_wr0_cycle", wr_cyc_q[0] - rel, 1);
            chk("init_wr1_gap", wr_cyc_q[1] - wr_cyc_q[0], 35);
            chk("init_done_cycle", cyc - wr_cyc_q[1], 35);
        end
        chk("dac_ready_during_init", dr_init, 0);

        // Table-driven DAC writes from IDLE
        foreach (vecs[i]) begin
            @(negedge clk);
            dac_valid = 1'b1;
            dac_data  = vecs[i].data;
            exp_wr.push_back(vecs[i].data);
            e = cyc;
            #1 chk("dac_ready", dac_ready, 1);
            @(posedge clk);
            #1 dac_valid = 1'b0;
            dac_data = $urandom;
            chk("dac_ready_drop", dac_ready, 0);
            @(negedge clk);
            #1 chk("dac_flag_latency", last_wr_cyc - e, vecs[i].exp_lat);
            n = 0;
            while (busy && n < 100) begin n++; @(negedge clk); #1; end
            chk("dac_busy_len", n, vecs[i].exp_busy);
        end

        // Periodic ADC reads, first sample BEEF
        @(negedge clk);
        sample_en = 1'b1;
        e = cyc;
        n = 0;
        while (adcs < 2 && n < 300) begin @(negedge clk); n++; end
        chk("adc_two_samples", adcs, 2);
        if (rd_cyc_q.size() >= 2) begin
            chk("rd_first_cycle", rd_cyc_q[0] - e, DIV + 1);
            chk("rd_period", rd_cyc_q[1] - rd_cyc_q[0], DIV);
        end
        chk("no_overrun_uncontended", ovr, 0);

        // Contention: DAC always valid, reads starved past ticks
        @(posedge clk);
        #1;
        dac_data = $urandom;
        dac_valid = 1'b1;
        auto_dac = 1'b1;
        gi0 = grants.size();
        repeat (600) @(posedge clk);
        #1;
        dac_valid = 1'b0;
        auto_dac = 1'b0;
        sample_en = 1'b0;
        gi1 = grants.size();
        repeat (150) @(negedge clk);
        #1;
        first_r = -1;
        for (int i = gi0; i < gi1; i++) if (grants[i] && first_r < 0) first_r = i;
        viol = 0;
        if (first_r >= 0) for (int i = first_r + 1; i < gi1; i++) if (grants[i] == grants[i-1]) viol++;
        chk("contention_read_served", first_r >= 0, 1);
        chk("grant_alternation", viol, 0);
        chk("overrun_seen", ovr > 0, 1);
        chk("overrun_single_pulse", ovr_double, 0);
        chk("tick_balance", ticks, reads + ovr);
        chk("adc_per_read", adcs, reads);
        chk("wr_queue_drained", exp_wr.size(), 0);
        chk("adc_queue_drained", exp_adc.size(), 0);
        chk("idle_after_drain", busy, 0);

        // Reset in the middle of a read transfer
        @(negedge clk);
        sample_en = 1'b1;
        r0 = reads;
        n = 0;
        while (reads == r0 && n < 100) begin @(negedge clk); #1; n++; end
        chk("reset_test_read_seen", reads, r0 + 1);
        sample_en = 1'b0;
        repeat (11) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_adc_valid", adc_valid, 0);
        chk("mid_rst_writ_flag", spi_writ_flag, 0);
        chk("mid_rst_read_flag", spi_read_flag, 0);
        chk("mid_rst_init_done", init_done, 0);
        chk("mid_rst_adc_data", adc_data, 0);
        exp_adc.delete();
        exp_wr.delete();
        adcs0 = adcs;
        repeat (3) @(negedge clk);
        exp_wr.push_back(32'hA500_0001);
        exp_wr.push_back(32'h5A00_0002);
        wi = wr_cyc_q.size();
        rst_n = 1'b1;
        rel = cyc;
        n = 0;
        while (!init_done && n < 200) begin @(negedge clk); #1; n++; end
        chk("reinit_done", init_done, 1);
        chk("reinit_wr_count", wr_cyc_q.size() - wi, 2);
        if (wr_cyc_q.size() - wi == 2) chk("reinit_wr0_cycle", wr_cyc_q[wi] - rel, 1);
        chk("no_adc_after_abort", adcs - adcs0, 0);
        chk("reinit_wr_drained", exp_wr.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
